alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 77 +++++++
 tb/tb_alu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered single-cycle ALU: parity, popcount and rotate of A_in.
// Alu_out is the only state; it clears asynchronously while rst_n is low.
module alu #(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] A_in,
  input  logic [DATA_WIDTH-1:0] B_in,
  output logic [DATA_WIDTH-1:0] Alu_out
);

  localparam int SHW  = $clog2(DATA_WIDTH);
  localparam int CNTW = SHW + 1;

  localparam logic [2:0] OP_PARITY = 3'b000;
  localparam logic [2:0] OP_ROTR   = 3'b001;
  localparam logic [2:0] OP_ROTL   = 3'b010;
  localparam logic [2:0] OP_POPCNT = 3'b011;

  logic [SHW-1:0]                amt_r;
  logic [SHW-1:0]                amt_l;
  logic [SHW-1:0]                amt_sel;
  logic [SHW:0][DATA_WIDTH-1:0]  rot_stage;
  logic [CNTW-1:0]               pop_cnt;
  logic                          parity;
  logic [DATA_WIDTH-1:0]         alu_d;
  logic [DATA_WIDTH-1:0]         alu_q;

  // Only the low log2 bits of B_in are looked at, so upper bits can be X freely.
  assign amt_r = B_in[SHW-1:0];
  // A left rotate by N is a right rotate by (DATA_WIDTH - N) mod DATA_WIDTH.
  assign amt_l   = -amt_r;
  assign amt_sel = (opcode == OP_ROTL) ? amt_l : amt_r;

  assign rot_stage[0] = A_in;

  genvar s;
  for (s = 0; s < SHW; s++) begin : g_rot
    localparam int K = 1 << s;
    assign rot_stage[s+1] = amt_sel[s]
                          ? {rot_stage[s][K-1:0], rot_stage[s][DATA_WIDTH-1:K]}
                          : rot_stage[s];
  end

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pop_cnt = pop_cnt + CNTW'(A_in[i]);
    end
  end

  assign parity = ^A_in;

  always_comb begin
    alu_d = '0;
    case (opcode)
      OP_PARITY: alu_d[0]         = parity;
      OP_ROTR:   alu_d            = rot_stage[SHW];
      OP_ROTL:   alu_d            = rot_stage[SHW];
      OP_POPCNT: alu_d[CNTW-1:0]  = pop_cnt;
      default:   alu_d            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q <= '0;
    end else begin
      alu_q <= alu_d;
    end
  end

  assign Alu_out = alu_q;

endmodule

// File: tb/tb_alu.sv
// Table-driven bench for alu with an expected-value queue and reset/hold sequences.
module tb_alu;

  localparam int W = 256;

  logic          clk;
  logic          rst_n;
  logic [2:0]    opcode;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic [W-1:0]  alu_out;

  int total;
  int bad;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t tbl[$];

  alu #(.DATA_WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .opcode  (opcode),
    .A_in    (a_in),
    .B_in    (b_in),
    .Alu_out (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    int n;
    logic [W-1:0] r;
    n = int'(b[7:0]);
    r = '0;
    case (op)
      3'd0: r[0] = ($countones(a) % 2 == 1);
      3'd1: r = (n == 0) ? a : ((a >> n) | (a << (W - n)));
      3'd2: r = (n == 0) ? a : ((a << n) | (a >> (W - n)));
      3'd3: r = W'($countones(a));
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] exp);
    total++;
    if (alu_out !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, alu_out, exp);
    end
  endtask

  task automatic check_pop(input string name);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      check(name, exp_q.pop_front());
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the following rising edge.
  task automatic apply(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input string name);
    @(negedge clk);
    opcode = op;
    a_in   = a;
    b_in   = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check_pop(name);
  endtask

  logic [W-1:0] ones;
  logic [W-1:0] held;

  initial begin
    total  = 0;
    bad    = 0;
    ones   = '1;
    rst_n  = 1'b1;
    opcode = 3'd3;
    a_in   = ones;
    b_in   = '0;

    // Async reset with no clock edge in between.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_async", '0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", '0);
    @(negedge clk);
    rst_n = 1'b1;

    tbl.push_back('{3'd0, W'(8'hAC), '0, W'(0), "parity_ac"});
    tbl.push_back('{3'd0, W'(8'hAD), '0, W'(1), "parity_ad"});
    tbl.push_back('{3'd0, ones, ones, W'(0), "parity_ones"});
    tbl.push_back('{3'd3, W'(8'hAD), '0, W'(5), "pop_ad"});
    tbl.push_back('{3'd3, W'(8'hED), '0, W'(6), "pop_ed"});
    tbl.push_back('{3'd3, '0, ones, W'(0), "pop_zero"});
    tbl.push_back('{3'd3, ones, '0, W'(256), "pop_ones"});
    tbl.push_back('{3'd1, W'(8'hAD), W'(3), (W'(8'h15) | (W'(3'b101) << 253)), "rotr_3"});
    tbl.push_back('{3'd1, W'(8'hAD), W'(256), W'(8'hAD), "rotr_wrap"});
    tbl.push_back('{3'd2, (W'(8'hAD) << 248), W'(3), ((W'(8'h68) << 248) | W'(3'b101)), "rotl_3"});
    tbl.push_back('{3'd2, W'(1), W'(255), (W'(1) << 255), "rotl_255"});
    tbl.push_back('{3'd1, W'(1), (ones << 8) | W'(1), (W'(1) << 255), "rotr_upper_b"});
    tbl.push_back('{3'd7, ones, ones, W'(0), "rsv_111"});
    tbl.push_back('{3'd4, ones, '0, W'(0), "rsv_100"});

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].name);
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op = 3'($urandom_range(0, 7));
      a  = rand_word();
      b  = rand_word();
      apply(op, a, b, model(op, a, b), "random");
    end

    // Output holds while inputs change between edges.
    apply(3'd3, W'(8'hFF), '0, W'(8), "hold_setup");
    held = W'(8);
    #2;
    opcode = 3'd7;
    a_in   = ones;
    #1;
    check("hold_mid", held);
    @(negedge clk);
    check("hold_before_edge", held);
    @(posedge clk);
    #1;
    check("hold_next_edge", '0);

    // Reset mid-operation drops the pending result; first edge after release loads current inputs.
    @(negedge clk);
    opcode = 3'd3;
    a_in   = ones;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid", '0);
    @(posedge clk);
    #1;
    check("reset_mid_edge", '0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(W'(256));
    @(posedge clk);
    #1;
    check_pop("reset_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
